// File: rtl/ram_responder_if.sv
// Request/response bus between an initiator (core fetch or LSU) and a word SRAM responder.
interface ram_responder_if;
  logic        req;
  logic        gnt;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, we, be, addr, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, we, be, addr, wdata,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/ram_responder.sv
// Word-addressed SRAM responder: grant handshake, bounded outstanding requests,
// fixed-latency in-order responses, error flagging and optional LFSR grant stalls.
module ram_responder #(
  parameter int unsigned DEPTH           = 4096,
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
  parameter int unsigned LATENCY         = 1,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter bit          RandomGntStall  = 1'b0
) (
  input logic            clk,
  input logic            rst_n,
  ram_responder_if.slave bus
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + (33'(DEPTH) << 2);
  localparam logic [2:0]  MAX_CNT  = 3'(MAX_OUTSTANDING);

  logic [31:0]        mem [DEPTH];
  logic [15:0]        lfsr;
  logic [2:0]         cnt;
  logic               stall;
  logic               gnt;
  logic               err;
  logic [AW-1:0]      idx;
  logic [LATENCY-1:0] pv;
  logic [LATENCY-1:0] pe;
  logic [31:0]        pd [LATENCY];

  assign stall = RandomGntStall & lfsr[0];
  assign gnt   = bus.req & (cnt < MAX_CNT) & ~stall;
  assign idx   = AW'((bus.addr - BASE_ADDR) >> 2);
  assign err   = (bus.addr[1:0] != 2'b00) | (bus.addr < BASE_ADDR)
               | ({1'b0, bus.addr} >= END_ADDR);

  assign bus.gnt    = gnt;
  assign bus.rvalid = pv[LATENCY-1];
  assign bus.rdata  = pd[LATENCY-1];
  assign bus.err    = pe[LATENCY-1];

  // Stall source: 16-bit Fibonacci LFSR, taps 16,14,13,11, free-running after reset.
  always_ff @(posedge clk) begin
    if (!rst_n) lfsr <= 16'hACE1;
    else        lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  // Outstanding count: up on grant, down on response, unchanged when both coincide.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      case ({gnt, pv[LATENCY-1]})
        2'b10:   cnt <= cnt + 3'd1;
        2'b01:   cnt <= cnt - 3'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Byte-lane write on an error-free granted write; contents are never reset.
  always_ff @(posedge clk) begin
    if (gnt && bus.we && !err) begin
      for (int unsigned k = 0; k < 4; k++) begin
        if (bus.be[k]) mem[idx][8*k +: 8] <= bus.wdata[8*k +: 8];
      end
    end
  end

  // Response pipe: stage 0 captures the word at the grant edge; data stages only
  // load behind a valid entry, so the last stage holds its value between responses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pv <= '0;
      pe <= '0;
      for (int unsigned k = 0; k < LATENCY; k++) pd[k] <= '0;
    end else begin
      pv[0] <= gnt;
      if (gnt) begin
        pe[0] <= err;
        pd[0] <= (bus.we | err) ? '0 : mem[idx];
      end
      for (int unsigned k = 1; k < LATENCY; k++) begin
        pv[k] <= pv[k-1];
        if (pv[k-1]) begin
          pe[k] <= pe[k-1];
          pd[k] <= pd[k-1];
        end
      end
    end
  end

  // An initiator must hold req and every request field stable until granted.
  property p_req_hold;
    @(posedge clk) disable iff (!rst_n)
      (bus.req && !gnt) |=> (bus.req && $stable(bus.we) && $stable(bus.be)
                             && $stable(bus.addr) && $stable(bus.wdata));
  endproperty
  a_req_hold: assert property (p_req_hold);

endmodule
